// File: rtl/dmem_write_buffer_if.sv
// Request/acknowledge bus between the data-memory write buffer and a
// multi-cycle data memory. The buffer is the master; the memory is the slave.
interface dmem_write_buffer_if #(
    parameter int N = 64
) ();
    logic         mem_req;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic [N-1:0] mem_rdata;
    logic         mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/dmem_write_buffer.sv
// Data-memory write buffer between the MEM stage and a multi-cycle memory.
// Stores are posted into a DEPTH-entry FIFO and drained in the background;
// loads are served from the bus and stall the pipeline until data returns.
// Optional macro DMEM_WB_FORWARD_EN: when defined, loads that match a buffered
// store (doubleword granularity) are forwarded from the youngest match with no
// stall; when undefined, every load waits for an empty buffer and reads the bus.
module dmem_write_buffer #(
    parameter int N        = 64,
    parameter int DEPTH    = 4,
    parameter int ADDR_LSB = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         DM_addr,
    input  logic [N-1:0]         DM_writeData,
    input  logic                 DM_writeEnable,
    input  logic                 DM_readEnable,
    output logic [N-1:0]         DM_readData,
    output logic                 stall,
    dmem_write_buffer_if.master  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ADDR_LSB >= N) begin : g_param_check
        $error("dmem_write_buffer: DEPTH must be a power of two >= 2 and ADDR_LSB < N");
    end

    typedef enum logic [1:0] {
        IDLE,
        WR_BUS,
        RD_BUS
    } state_t;

    state_t state;
    state_t state_next;

    logic [N-1:0]     addr_q [DEPTH];
    logic [N-1:0]     data_q [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             rd_valid;
    logic [N-1:0]     rd_q;

    logic             store;
    logic             load;
    logic             full;
    logic             push;
    logic             pop;
    logic             hit;
    logic [N-1:0]     fwd_data;
    logic             rd_issue;

    // A simultaneous load and store is handled as a store; flag it in simulation.
    assert property (@(posedge clk) disable iff (!reset) !(DM_readEnable && DM_writeEnable))
        else $error("dmem_write_buffer: DM_readEnable and DM_writeEnable both set");

    assign store = DM_writeEnable;
    assign load  = DM_readEnable && !DM_writeEnable;
    assign full  = (count == CNT_W'(DEPTH));
    assign push  = reset && store && !full;
    assign pop   = reset && (state == WR_BUS) && bus.mem_ack;

`ifdef DMEM_WB_FORWARD_EN
    // Search buffered stores oldest to youngest so the youngest match wins.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count &&
                addr_q[head + PTR_W'(i)][N-1:ADDR_LSB] == DM_addr[N-1:ADDR_LSB]) begin
                hit      = 1'b1;
                fwd_data = data_q[head + PTR_W'(i)];
            end
        end
    end

    assign rd_issue = load && !hit && !rd_valid;
`else
    assign hit      = 1'b0;
    assign fwd_data = '0;
    assign rd_issue = load && !rd_valid && (count == '0);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: a pending load miss beats draining; bus phases end on ack.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (rd_issue) begin
                    state_next = RD_BUS;
                end else if (count != '0) begin
                    state_next = WR_BUS;
                end
            end
            WR_BUS: begin
                if (bus.mem_ack) begin
                    state_next = IDLE;
                end
            end
            RD_BUS: begin
                if (bus.mem_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered bus outputs, held from request launch until the cycle after ack.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else if (state == IDLE && state_next == WR_BUS) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= addr_q[head];
            bus.mem_wdata <= data_q[head];
        end else if (state == IDLE && state_next == RD_BUS) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= DM_addr;
            bus.mem_wdata <= '0;
        end else if (state != IDLE && bus.mem_ack) begin
            bus.mem_req   <= 1'b0;
        end
    end

    // Captured load-miss data, presented for exactly one cycle after the ack.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_valid <= 1'b0;
            rd_q     <= '0;
        end else if (state == RD_BUS && bus.mem_ack) begin
            rd_valid <= 1'b1;
            rd_q     <= bus.mem_rdata;
        end else begin
            rd_valid <= 1'b0;
        end
    end

    // FIFO pointers and occupancy; push and pop in one cycle leave count unchanged.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; entries are only meaningful below count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= DM_addr;
            data_q[tail] <= DM_writeData;
        end
    end

    // Pipeline-facing results: stall on a full buffer or an unresolved load.
    always_comb begin
        stall       = 1'b0;
        DM_readData = '0;
        if (reset) begin
            if (store) begin
                stall = full;
            end else if (load) begin
                if (rd_valid) begin
                    DM_readData = rd_q;
                end else if (hit) begin
                    DM_readData = fwd_data;
                end else begin
                    stall = 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_write_buffer.sv
// Testbench for dmem_write_buffer. A behavioural memory answers the bus with a
// programmable ack latency; a program-order shadow memory gives the value every
// load must return, and a queue of accepted stores gives the required write order.
// Works with DMEM_WB_FORWARD_EN either defined or undefined.
module tb_dmem_write_buffer;
    logic        clk;
    logic        reset;
    logic [63:0] DM_addr;
    logic [63:0] DM_writeData;
    logic        DM_writeEnable;
    logic        DM_readEnable;
    logic [63:0] DM_readData;
    logic        stall;

    dmem_write_buffer_if #(.N(64)) bus ();

    dmem_write_buffer #(.N(64), .DEPTH(4), .ADDR_LSB(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .DM_addr        (DM_addr),
        .DM_writeData   (DM_writeData),
        .DM_writeEnable (DM_writeEnable),
        .DM_readEnable  (DM_readEnable),
        .DM_readData    (DM_readData),
        .stall          (stall),
        .bus            (bus)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] d;
    } wr_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          wr_count = 0;
    int          rd_count = 0;
    int          ack_lat  = 0;
    int          lat_cnt  = 0;
    bit          acked    = 0;
    bit          resp_en  = 0;
    bit          resp_hold = 0;
    bit          rand_lat = 0;
    logic [63:0] exp_rd_addr = '0;
    wr_t         exp_wr[$];
    wr_t         cur_wr;
    logic [63:0] mem_img [logic [60:0]];
    logic [63:0] shadow  [logic [60:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [60:0] dw(input logic [63:0] a);
        return a[63:3];
    endfunction

    function automatic logic [63:0] init_val(input logic [63:0] a);
        return {~a[31:0], a[31:0]};
    endfunction

    function automatic logic [63:0] shadow_val(input logic [63:0] a);
        if (shadow.exists(dw(a))) return shadow[dw(a)];
        return init_val(a);
    endfunction

    // Behavioural memory: acks after ack_lat waiting cycles and checks every transaction.
    always @(negedge clk) begin
        if (resp_en) begin
            bus.mem_ack = 1'b0;
            if (!reset) begin
                lat_cnt = 0;
                acked   = 0;
            end else if (bus.mem_req === 1'b1 && !acked && !resp_hold) begin
                if (lat_cnt >= ack_lat) begin
                    bus.mem_ack = 1'b1;
                    acked       = 1;
                    lat_cnt     = 0;
                    if (bus.mem_we === 1'b1) begin
                        wr_count++;
                        mem_img[dw(bus.mem_addr)] = bus.mem_wdata;
                        n_checks++;
                        if (exp_wr.size() == 0) begin
                            $display("[TB] FAIL unexpected_write got addr=%h data=%h required none",
                                     bus.mem_addr, bus.mem_wdata);
                        end else begin
                            cur_wr = exp_wr.pop_front();
                            if (bus.mem_addr !== cur_wr.a || bus.mem_wdata !== cur_wr.d)
                                $display("[TB] FAIL write_order got addr=%h data=%h required addr=%h data=%h",
                                         bus.mem_addr, bus.mem_wdata, cur_wr.a, cur_wr.d);
                            else
                                n_pass++;
                        end
                    end else begin
                        rd_count++;
                        bus.mem_rdata = mem_img.exists(dw(bus.mem_addr)) ?
                                        mem_img[dw(bus.mem_addr)] : init_val(bus.mem_addr);
                        n_checks++;
                        if (bus.mem_addr !== exp_rd_addr)
                            $display("[TB] FAIL read_addr got %h required %h", bus.mem_addr, exp_rd_addr);
                        else
                            n_pass++;
                    end
                    if (rand_lat) ack_lat = $urandom_range(0, 3);
                end else begin
                    lat_cnt++;
                end
            end else if (bus.mem_req !== 1'b1) begin
                acked = 0;
            end
        end
    end

    task automatic do_store(input logic [63:0] a, input logic [63:0] d,
                            output int sc, output int wr_at);
        @(negedge clk);
        DM_writeEnable = 1'b1;
        DM_readEnable  = 1'b0;
        DM_addr        = a;
        DM_writeData   = d;
        #1;
        sc = 0;
        while (stall === 1'b1 && sc < 200) begin
            @(negedge clk);
            #1;
            sc++;
        end
        if (sc >= 200) begin
            n_checks++;
            $display("[TB] FAIL store_timeout addr=%h got stall=%b required 0", a, stall);
        end
        wr_at = wr_count;
        shadow[dw(a)] = d;
        exp_wr.push_back('{a: a, d: d});
        @(posedge clk);
        #1;
        DM_writeEnable = 1'b0;
    endtask

    task automatic do_load(input logic [63:0] a, output logic [63:0] d, output int sc);
        @(negedge clk);
        DM_readEnable  = 1'b1;
        DM_writeEnable = 1'b0;
        DM_addr        = a;
        exp_rd_addr    = a;
        #1;
        sc = 0;
        while (stall === 1'b1 && sc < 200) begin
            @(negedge clk);
            #1;
            sc++;
        end
        if (sc >= 200) begin
            n_checks++;
            $display("[TB] FAIL load_timeout addr=%h got stall=%b required 0", a, stall);
        end
        d = DM_readData;
        @(posedge clk);
        #1;
        DM_readEnable = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        #1;
        while ((exp_wr.size() != 0 || bus.mem_req !== 1'b0) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (n >= budget)
            $display("[TB] FAIL drain_timeout got pending=%0d required 0", exp_wr.size());
        else
            n_pass++;
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        resp_en        = 0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = '0;
        DM_addr        = '0;
        DM_writeData   = '0;
        DM_writeEnable = 1'b0;
        DM_readEnable  = 1'b0;
        repeat (2) begin
            @(negedge clk);
            bus.mem_ack = !bus.mem_ack;
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (stall !== 1'b0) $display("[TB] FAIL reset_stall got %b required 0", stall); else n_pass++;
        n_checks++;
        if (bus.mem_req !== 1'b0) $display("[TB] FAIL reset_req got %b required 0", bus.mem_req); else n_pass++;
        n_checks++;
        if (DM_readData !== 64'h0) $display("[TB] FAIL reset_rdata got %h required 0", DM_readData); else n_pass++;
        n_checks++;
        if (dut.count !== '0) $display("[TB] FAIL reset_count got %0d required 0", dut.count); else n_pass++;
        bus.mem_ack = 1'b0;
        reset       = 1'b1;
        resp_en     = 1;
        @(negedge clk);
        #1;
        n_checks++;
        if (stall !== 1'b0) $display("[TB] FAIL post_reset_stall got %b required 0", stall); else n_pass++;
        n_checks++;
        if (bus.mem_req !== 1'b0) $display("[TB] FAIL post_reset_req got %b required 0", bus.mem_req); else n_pass++;
    endtask

    task automatic test_posted_store();
        int sc, wa, w0;
        ack_lat = 3;
        w0 = wr_count;
        do_store(64'h40, 64'hDEAD_BEEF, sc, wa);
        n_checks++;
        if (sc != 0) $display("[TB] FAIL posted_store_stall got %0d cycles required 0", sc); else n_pass++;
        wait_drain(100);
        n_checks++;
        if (wr_count - w0 != 1) $display("[TB] FAIL posted_store_writes got %0d required 1", wr_count - w0); else n_pass++;
    endtask

    task automatic test_forwarding();
        int sc, wa, w0, r0;
        logic [63:0] d;
        w0 = wr_count;
        r0 = rd_count;
`ifdef DMEM_WB_FORWARD_EN
        resp_hold = 1;
        do_store(64'h80, 64'h11, sc, wa);
        do_store(64'h80, 64'h22, sc, wa);
        do_load(64'h80, d, sc);
        n_checks++;
        if (d !== 64'h22) $display("[TB] FAIL fwd_data got %h required 22", d); else n_pass++;
        n_checks++;
        if (sc != 0) $display("[TB] FAIL fwd_stall got %0d cycles required 0", sc); else n_pass++;
        n_checks++;
        if (rd_count != r0) $display("[TB] FAIL fwd_no_read got %0d reads required 0", rd_count - r0); else n_pass++;
        resp_hold = 0;
        wait_drain(100);
`else
        ack_lat = 1;
        do_store(64'h80, 64'h11, sc, wa);
        do_store(64'h80, 64'h22, sc, wa);
        do_load(64'h80, d, sc);
        n_checks++;
        if (d !== 64'h22) $display("[TB] FAIL ordered_load_data got %h required 22", d); else n_pass++;
        n_checks++;
        if (sc == 0) $display("[TB] FAIL ordered_load_stall got %0d cycles required >0", sc); else n_pass++;
        n_checks++;
        if (wr_count - w0 != 2) $display("[TB] FAIL ordered_drain got %0d writes required 2", wr_count - w0); else n_pass++;
        n_checks++;
        if (rd_count - r0 != 1) $display("[TB] FAIL ordered_read got %0d reads required 1", rd_count - r0); else n_pass++;
        wait_drain(100);
`endif
        n_checks++;
        if (wr_count - w0 != 2) $display("[TB] FAIL fwd_writes got %0d required 2", wr_count - w0); else n_pass++;
    endtask

    task automatic test_full_buffer();
        int sc, wa, w0, sc5, wr5;
        ack_lat   = 0;
        resp_hold = 1;
        w0 = wr_count;
        for (int i = 0; i < 4; i++) begin
            do_store(64'h200 + 64'(8 * i), 64'hA000 + 64'(i), sc, wa);
            n_checks++;
            if (sc != 0) $display("[TB] FAIL full_store%0d_stall got %0d required 0", i, sc); else n_pass++;
        end
        fork
            do_store(64'h220, 64'hA004, sc5, wr5);
            begin
                repeat (4) @(negedge clk);
                #2;
                resp_hold = 0;
            end
        join
        n_checks++;
        if (sc5 == 0) $display("[TB] FAIL full_stall got %0d cycles required >0", sc5); else n_pass++;
        n_checks++;
        if (wr5 - w0 != 1) $display("[TB] FAIL full_push_after_ack got %0d writes required 1", wr5 - w0); else n_pass++;
        wait_drain(200);
        n_checks++;
        if (wr_count - w0 != 5) $display("[TB] FAIL full_writes got %0d required 5", wr_count - w0); else n_pass++;
    endtask

    task automatic test_load_miss();
        int sc, r0;
        logic [63:0] d;
        ack_lat = 2;
        mem_img[dw(64'h100)] = 64'h1234;
        shadow[dw(64'h100)]  = 64'h1234;
        r0 = rd_count;
        do_load(64'h100, d, sc);
        n_checks++;
        if (sc != 4) $display("[TB] FAIL miss_stall got %0d cycles required 4", sc); else n_pass++;
        n_checks++;
        if (d !== 64'h1234) $display("[TB] FAIL miss_data got %h required 1234", d); else n_pass++;
        n_checks++;
        if (rd_count - r0 != 1) $display("[TB] FAIL miss_reads got %0d required 1", rd_count - r0); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (DM_readData !== 64'h0) $display("[TB] FAIL idle_rdata got %h required 0", DM_readData); else n_pass++;
    endtask

    task automatic test_random();
        int sc, wa, op;
        logic [63:0] a, d, exp;
        rand_lat = 1;
        for (int k = 0; k < 300; k++) begin
            op = $urandom_range(0, 9);
            a  = 64'h1000 + 64'(8 * $urandom_range(0, 7));
            if (op < 4) begin
                d = {$urandom, $urandom};
                do_store(a, d, sc, wa);
            end else if (op < 7) begin
                exp = shadow_val(a);
                do_load(a, d, sc);
                n_checks++;
                if (d !== exp) $display("[TB] FAIL rand_load addr=%h got %h required %h", a, d, exp); else n_pass++;
            end else begin
                @(negedge clk);
            end
        end
        wait_drain(200);
        rand_lat = 0;
    endtask

    task automatic test_reset_mid();
        int sc, wa, w0, n;
        ack_lat   = 0;
        resp_hold = 1;
        for (int i = 0; i < 3; i++) begin
            do_store(64'h300 + 64'(8 * i), 64'hB000 + 64'(i), sc, wa);
        end
        n = 0;
        while (bus.mem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (bus.mem_req !== 1'b1) $display("[TB] FAIL mid_req_up got %b required 1", bus.mem_req); else n_pass++;
        w0 = wr_count;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.mem_req !== 1'b0) $display("[TB] FAIL mid_reset_req got %b required 0", bus.mem_req); else n_pass++;
        n_checks++;
        if (dut.count !== '0) $display("[TB] FAIL mid_reset_count got %0d required 0", dut.count); else n_pass++;
        exp_wr.delete();
        shadow    = mem_img;
        reset     = 1'b1;
        resp_hold = 0;
        repeat (20) @(negedge clk);
        #1;
        n_checks++;
        if (wr_count != w0) $display("[TB] FAIL mid_no_writes got %0d writes required 0", wr_count - w0); else n_pass++;
        n_checks++;
        if (bus.mem_req !== 1'b0) $display("[TB] FAIL mid_idle_req got %b required 0", bus.mem_req); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_posted_store();
        test_forwarding();
        test_full_buffer();
        test_load_miss();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dmem_write_buffer.md
Name: dmem_write_buffer

Overview:
- Data-memory interface placed directly downstream of the pipeline's MEM-stage data port (DM_addr, DM_writeData, DM_writeEnable, DM_readEnable, DM_readData).
- Decouples the pipeline from a multi-cycle data memory using a req/ack bus.
- Posts stores into a DEPTH-entry FIFO write buffer and drains it in the background.
- Serves loads from the buffer (store-to-load forwarding) or from the bus, and stalls the pipeline while a load miss or a full buffer is pending.

Parameters:
N, 64, data and address width.
DEPTH, 4, write-buffer entries. Power of two, at least 2.
ADDR_LSB, 3, low address bits ignored for matching (doubleword granularity).

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-low reset.
DM_addr  input  N  load/store address from the MEM stage.
DM_writeData  input  N  store data.
DM_writeEnable  input  1  store request this cycle.
DM_readEnable  input  1  load request this cycle.
DM_readData  output  N  load result, valid when DM_readEnable=1 and stall=0.
stall  output  1  freezes PC and all pipeline registers while 1.
mem_req  output  1  bus request; held until mem_ack.
mem_we  output  1  1 = write transaction, 0 = read transaction.
mem_addr  output  N  bus address.
mem_wdata  output  N  bus write data.
mem_rdata  input  N  bus read data, valid with mem_ack.
mem_ack  input  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0 at an edge): FIFO empty (count=0, head=tail=0), FSM returns to IDLE, rd_valid=0, all registered outputs 0. stall is forced to 0 while reset=0. An in-flight bus transaction is abandoned; mem_req is 0 after the edge.
- FSM states:
  - IDLE: if a load miss is pending, go to RD_BUS. Else if count>0, go to WR_BUS. Loads take priority over draining.
  - WR_BUS: mem_req=1, mem_we=1, addr/data from the head entry. On mem_ack: pop head, return to IDLE.
  - RD_BUS: mem_req=1, mem_we=0, mem_addr=DM_addr. On mem_ack: rd_q<=mem_rdata, rd_valid<=1, go to IDLE.
- Bus outputs are registered and stable from the cycle mem_req rises until the cycle after mem_ack. No new request is issued in the ack cycle, so there is at least one idle cycle between transactions.
- Store:
  - When DM_writeEnable=1 and count<DEPTH, push {addr,data} at tail with stall=0, giving a 1-cycle store.
  - When count==DEPTH, stall=1 until a pop frees an entry. Full is evaluated on the pre-pop count, so a store in the same cycle as a drain ack still stalls that cycle and pushes the next.
- Load hit:
  - Hit means some valid entry has addr[N-1:ADDR_LSB] equal to DM_addr[N-1:ADDR_LSB].
  - DM_readData is the youngest matching entry's data, combinationally, with stall=0 (0-cycle penalty).
- Load miss:
  - stall=1; the load waits for any WR_BUS in flight to complete, then runs RD_BUS.
  - The cycle after mem_ack: stall=0 and DM_readData=rd_q. rd_valid clears at the end of that cycle.
  - Stores to the same address cannot sit behind a miss, because a match would have been a hit.
- DM_readEnable and DM_writeEnable both 1: illegal. Handled as a store; the load is ignored. Flagged by a simulation assertion.
- A push while the head is being popped is legal; count stays unchanged.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- When no load is active, DM_readData=0.

Optional Feature:
DMEM_WB_FORWARD_EN
- Defined: load hits are served from the buffer as described above.
- Undefined: no address comparison logic. Every load stalls until count==0 and the FSM is IDLE, then performs RD_BUS. This gives strict ordering with a smaller area.

Test Plan:
- Reset: hold reset=0 for 2 cycles while mem_ack toggles -> stall=0, mem_req=0, DM_readData=0, count=0.
- Posted store: store 0xDEAD_BEEF to 0x40, mem_ack 3 cycles after mem_req -> stall=0 on the store cycle; bus shows mem_we=1, mem_addr=0x40, mem_wdata=0xDEAD_BEEF; exactly one write transaction.
- Forwarding (macro defined): stores 0x11 then 0x22 to 0x80, then load 0x80 the next cycle with bus ack withheld -> DM_readData=0x22, stall=0; no read transaction issued.
- Full buffer: 5 back-to-back stores (DEPTH=4) with ack held off -> stall=1 on the 5th store until the first mem_ack, then push accepted; 5 writes appear in order.
- Load miss: load 0x100 with buffer empty, memory returns 0x1234 with a 2-cycle ack latency -> stall=1 until the ack cycle; next cycle stall=0 and DM_readData=0x1234.
- Reset mid-transaction: assert reset during WR_BUS with 3 entries queued -> after the edge mem_req=0 and count=0; no further writes after reset is released.
